// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Purpose  : Data-memory req/ack port between the M stage and data memory.
// Ports    : memReq/memWe/memAddr/memWData/memBe driven by the stage (master);
//            memRData/memAck driven by the memory (slave).
// Revision : 1.0  initial release
// ============================================================================
interface mem_access_stage_if;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic [1:0]  memBe;
  logic [15:0] memRData;
  logic        memAck;

  modport master (
    output memReq, memWe, memAddr, memWData, memBe,
    input  memRData, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memWData, memBe,
    output memRData, memAck
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Memory-access stage of the 16-bit pipeline. Performs word/byte
//            loads and stores over a req/ack port, stalls upstream while a
//            transaction is outstanding, aborts with busErr after TIMEOUT
//            REQ cycles, and registers results for the MEM/WB buffer.
// Ports    : clk, rst_n (async active-low)
//            EX/M inputs : rWrite, mWrite, mRead, mByte, data1, op1data,
//                          op2data, r15data, op1, op2
//            stall       : upstream hold request
//            mem         : data-memory port (master modport)
//            MEM/WB outs : rWriteOut, aluOut, memDataOut, op1dataOut,
//                          op2dataOut, r15dataOut, op1Out, op2Out,
//                          alignErr, busErr
// Revision : 1.0  initial release
// ============================================================================
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  wire         clk,
  input  wire         rst_n,
  input  wire  [1:0]  rWrite,
  input  wire         mWrite,
  input  wire         mRead,
  input  wire         mByte,
  input  wire  [15:0] data1,
  input  wire  [15:0] op1data,
  input  wire  [15:0] op2data,
  input  wire  [15:0] r15data,
  input  wire  [3:0]  op1,
  input  wire  [3:0]  op2,
  output logic        stall,
  mem_access_stage_if.master mem,
  output logic [1:0]  rWriteOut,
  output logic [15:0] aluOut,
  output logic [15:0] memDataOut,
  output logic [15:0] op1dataOut,
  output logic [15:0] op2dataOut,
  output logic [15:0] r15dataOut,
  output logic [3:0]  op1Out,
  output logic [3:0]  op2Out,
  output logic        alignErr,
  output logic        busErr
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        byte_q, byte_d;
  logic        lane_q, lane_d;

  logic [1:0]  rWriteOut_q;
  logic [15:0] aluOut_q, memDataOut_q, op1dataOut_q, op2dataOut_q, r15dataOut_q;
  logic [3:0]  op1Out_q, op2Out_q;
  logic        alignErr_q, busErr_q;

  logic        w_memop, w_misalign, w_stall, w_res, w_align, w_bus;
  logic [7:0]  w_lane;
  logic [15:0] w_load, w_mdata;

  assign w_memop    = mRead | mWrite;
  assign w_misalign = ~mByte & data1[0];

  // Big-endian lanes: even byte address lives in bits 15:8.
  assign w_lane = lane_q ? mem.memRData[7:0] : mem.memRData[15:8];
  assign w_load = byte_q ? {{8{w_lane[7]}}, w_lane} : mem.memRData;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    byte_d  = byte_q;
    lane_d  = lane_q;
    w_stall = 1'b0;
    w_res   = 1'b0;
    w_align = 1'b0;
    w_bus   = 1'b0;
    w_mdata = 16'h0000;
    case (state_q)
      S_IDLE: begin
        if (!w_memop) begin
          w_res = 1'b1;
        end else if (w_misalign) begin
          w_res   = 1'b1;
          w_align = 1'b1;
        end else begin
          w_stall = 1'b1;
          state_d = S_REQ;
          cnt_d   = 8'd0;
          addr_d  = {data1[15:1], 1'b0};
          we_d    = mWrite;              // read+write together counts as a store
          wdata_d = mByte ? {op1data[7:0], op1data[7:0]} : op1data;
          be_d    = mByte ? (data1[0] ? 2'b01 : 2'b10) : 2'b11;
          byte_d  = mByte;
          lane_d  = data1[0];
        end
      end
      S_REQ: begin
        if (mem.memAck) begin
          w_res   = 1'b1;
          w_mdata = we_q ? 16'h0000 : w_load;
          state_d = S_IDLE;
        end else if (cnt_q == c_CNT_LAST) begin
          w_res   = 1'b1;
          w_bus   = 1'b1;
          state_d = S_IDLE;
        end else begin
          w_stall = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 16'h0000;
      we_q    <= 1'b0;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      byte_q  <= 1'b0;
      lane_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      byte_q  <= byte_d;
      lane_q  <= lane_d;
    end
  end

  // Results load only on a completing cycle; upstream holds its fields stable
  // through the stall, so they can be sampled straight from the inputs.
  // Error flags drop on every other edge so they mark exactly one result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rWriteOut_q  <= 2'b00;
      aluOut_q     <= 16'h0000;
      memDataOut_q <= 16'h0000;
      op1dataOut_q <= 16'h0000;
      op2dataOut_q <= 16'h0000;
      r15dataOut_q <= 16'h0000;
      op1Out_q     <= 4'h0;
      op2Out_q     <= 4'h0;
      alignErr_q   <= 1'b0;
      busErr_q     <= 1'b0;
    end else if (w_res) begin
      rWriteOut_q  <= (w_align | w_bus) ? 2'b00 : rWrite;
      aluOut_q     <= data1;
      memDataOut_q <= w_mdata;
      op1dataOut_q <= op1data;
      op2dataOut_q <= op2data;
      r15dataOut_q <= r15data;
      op1Out_q     <= op1;
      op2Out_q     <= op2;
      alignErr_q   <= w_align;
      busErr_q     <= w_bus;
    end else begin
      alignErr_q   <= 1'b0;
      busErr_q     <= 1'b0;
    end
  end

  // Stall is gated by reset so it drops at once even if a memory op is
  // still being presented while reset is held.
  assign stall        = rst_n & w_stall;

  assign mem.memReq   = (state_q == S_REQ);
  assign mem.memWe    = we_q;
  assign mem.memAddr  = addr_q;
  assign mem.memWData = wdata_q;
  assign mem.memBe    = be_q;

  assign rWriteOut    = rWriteOut_q;
  assign aluOut       = aluOut_q;
  assign memDataOut   = memDataOut_q;
  assign op1dataOut   = op1dataOut_q;
  assign op2dataOut   = op2dataOut_q;
  assign r15dataOut   = r15dataOut_q;
  assign op1Out       = op1Out_q;
  assign op2Out       = op2Out_q;
  assign alignErr     = alignErr_q;
  assign busErr       = busErr_q;

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (M) stage of the 16-bit pipeline, directly downstream of the EX/M pipeline buffer. Consumes the registered EX/M control and data fields, performs word or byte loads/stores over a req/ack data-memory port, and presents registered results to the MEM/WB buffer. The stage stalls upstream while a memory transaction is outstanding and aborts with an error flag if memory fails to acknowledge within a bounded number of cycles.

## Interface
- TIMEOUT, 16: maximum cycles in REQ before the access is aborted; legal range 2..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rWrite  in  2  writeback control from EX/M; passed through.
- mWrite, mRead, mByte  in  1 each  store, load, and byte-size flags.
- data1  in  16  ALU result; memory byte address for memory ops, writeback data otherwise.
- op1data  in  16  store data.
- op2data, r15data  in  16 each  passed through.
- op1, op2  in  4 each  register IDs; passed through.
- stall  out  1  upstream must hold all inputs stable while 1.
- memReq  out  1  memory request.
- memWe  out  1  1 = write.
- memAddr  out  16  word address, {data1[15:1],1'b0}.
- memWData  out  16  write data.
- memBe  out  2  byte enables; [1] = bits 15:8.
- memRData  in  16  read data; valid when memAck = 1.
- memAck  in  1  single-cycle acknowledge.
- rWriteOut  out  2, aluOut  out  16, memDataOut  out  16, op1dataOut, op2dataOut, r15dataOut  out  16, op1Out, op2Out  out  4  registered results to MEM/WB.
- alignErr, busErr  out  1 each  registered error flags, valid with the results.

## Operation
- States: IDLE, REQ.
- IDLE, no memory op (mRead = mWrite = 0): register pass-through fields at the edge; memDataOut = 0; stall = 0.
- IDLE, memory op, word access with data1[0] = 1 (misaligned): no request; results registered immediately with alignErr = 1, rWriteOut forced to 0; stall = 0.
- IDLE, legal memory op: stall = 1 combinationally; latch address, data, size, and type; go to REQ.
- mRead and mWrite both 1: treat as a write.
- REQ: memReq = 1; memAddr, memWe, memWData, memBe are driven from the latched values and held constant until memAck.
- Big-endian byte lanes: data1[0] = 0 selects bits 15:8.
  - Word: memBe = 11, memWData = op1data.
  - Byte: memBe = 10 when data1[0] = 0, 01 when data1[0] = 1; memWData = {op1data[7:0], op1data[7:0]}.
- Load data: word loads take memRData as-is. Byte loads take the selected lane and sign-extend it to 16 bits.
- REQ with memAck = 1: stall = 0 that cycle. At the edge, register the results (memDataOut is 0 for stores) and return to IDLE.
- Timeout counter: cleared on REQ entry, increments each REQ cycle without ack. When it reaches TIMEOUT−1 without ack:
  - drop stall;
  - register results with busErr = 1, rWriteOut = 0, memDataOut = 0;
  - return to IDLE.
- memAck in IDLE: ignored.
- Reset: all outputs and state go to 0/IDLE immediately. This includes memReq, so an in-flight transaction is abandoned.

## Timing
- Non-memory op presented in cycle N: results visible in N+1; no stall.
- Memory op presented in cycle N (IDLE): memReq high from N+1. With memAck in cycle N+k (k ≥ 1), stall is high for cycles N..N+k−1 and results are visible in N+k+1.
- Minimum memory-op occupancy is 2 cycles; back-to-back memory ops re-enter REQ one cycle after returning to IDLE.
- Error flags are valid for exactly the cycle their results are visible; they clear on the next registered update.

## Test plan
- Pass-through: data1 = 16'h1234, rWrite = 01, no mem op -> next cycle aluOut = 1234, rWriteOut = 01, stall never high.
- Word load: mRead = 1, data1 = 0x0040, memAck in the 3rd REQ cycle with memRData = 0xBEEF -> memAddr = 0x0040 and memBe = 11 held throughout; stall for 3 cycles; memDataOut = BEEF.
- Byte load with sign-extension: data1 = 0x0041, memRData = 0x12F0 -> memDataOut = FFF0. Repeat with data1 = 0x0040 -> 0x0012.
- Byte store: mWrite = mByte = 1, data1 = 0x0040, op1data = 0x00AB -> memWe = 1, memBe = 10, memWData = ABAB.
- Errors: word store to 0x0003 -> no memReq, alignErr = 1 next cycle. Load with no ack for TIMEOUT cycles -> busErr = 1, rWriteOut = 0, stall releases.
- Reset mid-REQ: assert rst_n = 0 while memReq = 1 -> memReq and stall go to 0 immediately; the first op after release behaves normally.
